// File: rtl/gcd_multi_pkg.sv
// Shared types and helpers for the multi-operand GCD engine.
// Default geometry plus the packed-operand extraction helper.
package gcd_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NUM_OPS = 3;
   localparam int MAX_WIDTH   = 64;
   localparam int MAX_NUM_OPS = 16;
   localparam int MAX_BUS_W   = MAX_WIDTH * MAX_NUM_OPS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_e;

   // Caller zero-extends its bus to MAX_BUS_W and truncates the result to its own width.
   function automatic logic [MAX_WIDTH-1:0] get_op(input logic [MAX_BUS_W-1:0] bus,
                                                    input int unsigned idx,
                                                    input int unsigned width);
      return MAX_WIDTH'(bus >> (idx * width));
   endfunction

endpackage

// File: rtl/gcd_multi_if.sv
// Start/valid handshake bundle for gcd_multi.
// The cycles signal exists only when GCD_CYCLE_CNT_EN is defined.
interface gcd_multi_if
   import gcd_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_OPS = DEF_NUM_OPS
`ifdef GCD_CYCLE_CNT_EN
   , parameter int CNT_W = 32
`endif
);

   logic                     start;
   logic [NUM_OPS*WIDTH-1:0] ops;
   logic                     busy;
   logic                     valid;
   logic [WIDTH-1:0]         D;
`ifdef GCD_CYCLE_CNT_EN
   logic [CNT_W-1:0]         cycles;

   modport master (output start, ops, input busy, valid, D, cycles);
   modport slave  (input start, ops, output busy, valid, D, cycles);
`else
   modport master (output start, ops, input busy, valid, D);
   modport slave  (input start, ops, output busy, valid, D);
`endif

endinterface

// File: rtl/gcd_multi_sub_step.sv
// Single combinational subtractive Euclid step.
// pair_done flags that y has reached zero and x holds the pair's GCD.
module gcd_sub_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] x_next,
   output logic [WIDTH-1:0] y_next,
   output logic             pair_done
);

   // Priority: finished pair, zero x swap, then subtract the smaller from the larger.
   always_comb begin
      x_next    = x;
      y_next    = y;
      pair_done = 1'b0;
      if (y == {WIDTH{1'b0}}) begin
         pair_done = 1'b1;
      end else if (x == {WIDTH{1'b0}}) begin
         x_next = y;
         y_next = {WIDTH{1'b0}};
      end else if (x >= y) begin
         x_next = x - y;
      end else begin
         y_next = y - x;
      end
   end

endmodule

// File: rtl/gcd_multi.sv
// Multi-operand GCD engine: folds acc = gcd(acc, op[i]) with one subtract step per cycle.
// Define GCD_CYCLE_CNT_EN to add the saturating busy-cycle counter on bus.cycles.
module gcd_multi
   import gcd_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_OPS = DEF_NUM_OPS
`ifdef GCD_CYCLE_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input logic        clk,
   input logic        reset,
   gcd_multi_if.slave bus
);

   localparam int              IDX_W    = $clog2(NUM_OPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_q [NUM_OPS];
   logic [WIDTH-1:0] op_d [NUM_OPS];
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] d_q, d_d;

   logic [WIDTH-1:0] x_next_s;
   logic [WIDTH-1:0] y_next_s;
   logic             pair_done_s;

   gcd_sub_step #(.WIDTH(WIDTH)) u_step (
      .x         (x_q),
      .y         (y_q),
      .x_next    (x_next_s),
      .y_next    (y_next_s),
      .pair_done (pair_done_s)
   );

   // Next-state logic; a start in any state restarts the job and suppresses the aborted valid.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      d_d     = d_q;
      if (bus.start) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            op_d[i] = WIDTH'(get_op(MAX_BUS_W'(bus.ops), i, WIDTH));
         end
         acc_d   = op_d[0];
         idx_d   = IDX_W'(1);
         state_d = LOAD;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               busy_d = 1'b0;
            end
            LOAD: begin
               x_d     = acc_q;
               y_d     = op_q[idx_q];
               state_d = CALC;
            end
            CALC: begin
               if (pair_done_s) begin
                  acc_d = x_q;
                  if (idx_q == LAST_IDX) begin
                     d_d     = x_q;
                     valid_d = 1'b1;
                     state_d = DONE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = LOAD;
                  end
               end else begin
                  x_d = x_next_s;
                  y_d = y_next_s;
               end
            end
            DONE: begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
            default: begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         for (int i = 0; i < NUM_OPS; i++) begin
            op_q[i] <= {WIDTH{1'b0}};
         end
         acc_q   <= {WIDTH{1'b0}};
         x_q     <= {WIDTH{1'b0}};
         y_q     <= {WIDTH{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         d_q     <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         d_q     <= d_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.valid = valid_q;
   assign bus.D     = d_q;

`ifdef GCD_CYCLE_CNT_EN
   logic [CNT_W-1:0] cycles_q, cycles_d;

   // Counts busy cycles of the current job, holding still in DONE and at all-ones.
   always_comb begin
      cycles_d = cycles_q;
      if (bus.start) begin
         cycles_d = {CNT_W{1'b0}};
      end else if (busy_q && (state_q != DONE) && (cycles_q != {CNT_W{1'b1}})) begin
         cycles_d = cycles_q + CNT_W'(1);
      end else begin
         cycles_d = cycles_q;
      end
   end

   // Cycle counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycles_q <= {CNT_W{1'b0}};
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign bus.cycles = cycles_q;
`endif

endmodule

// File: doc/gcd_multi.md
Name: gcd_multi

Overview:
- Parametrised successor to the fixed 3-operand, 16-bit GCD engine (gcd_top).
- Computes the greatest common divisor of NUM_OPS unsigned WIDTH-bit operands using iterative subtractive Euclid, one subtract step per cycle, folding operands left to right: acc = gcd(acc, op[i]).
- Adds abort-and-restart on start while busy, defined zero handling, and a busy output.
- Sits behind a start/valid handshake in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand and result width in bits.
- NUM_OPS, 3, number of operands; legal range 2..16.
- IDX_W, $clog2(NUM_OPS), operand index width (derived; not overridden).
- CNT_W, 32, cycle-counter width (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; samples ops on the same edge.
- ops  in  NUM_OPS*WIDTH  packed operands; op[i] = ops[i*WIDTH +: WIDTH].
- busy  out  1  high while a computation is in flight.
- valid  out  1  one-cycle pulse; D is new on this cycle.
- D  out  WIDTH  result; held until the next valid.
- cycles  out  CNT_W  present only with GCD_CYCLE_CNT_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, valid=0, D=0, all internal regs 0, cycles=0. Reset mid-operation discards the computation; no valid is produced.
- States:
  - IDLE: wait for start.
  - LOAD: x<=acc, y<=op_reg[idx].
  - CALC: one reduction step per cycle.
  - DONE: D<=acc, valid=1 for exactly one cycle, then IDLE.
- Start acceptance: start=1 at any edge, in any state, latches all operands into op_reg, acc<=op_reg[0], idx<=1, state<=LOAD, busy<=1.
  - Start during LOAD/CALC aborts the current job; the aborted job never produces valid.
  - Start in DONE is accepted; the pending valid pulse for the finished job still occurs that cycle.
- CALC step, priority order:
  - y==0: pair finished, acc<=x. If idx==NUM_OPS-1 go to DONE, else idx<=idx+1 and go to LOAD.
  - x==0: x<=y, y<=0.
  - x>=y: x<=x-y.
  - else: y<=y-x.
- Arithmetic: unsigned; subtraction never underflows by construction; no widening.
- Zero rules: gcd(a,0)=a; gcd(0,0)=0; all-zero operands give D=0 with a normal valid.
- Latency: minimum 2 cycles from the start edge to the valid edge per operand pair. The result is never available on the cycle after start. Worst case is bounded by NUM_OPS*(2^WIDTH+1) cycles.
- busy: 1 from the edge after start acceptance through the DONE cycle; 0 in IDLE.
- valid never asserts twice for one job. D is unchanged except in DONE.

Optional Feature:
- Macro GCD_CYCLE_CNT_EN.
- Defined: the cycles port exists. The counter clears on start acceptance, increments every cycle while busy, freezes at DONE, and saturates at all-ones. Reset value 0.
- Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Package gcd_pkg holds:
  - the state enum (IDLE, LOAD, CALC, DONE);
  - the default WIDTH and NUM_OPS constants;
  - a function extracting op[i] from the packed bus.
- One sub-module, gcd_sub_step: combinational single Euclid step with inputs x, y and outputs x_next, y_next, pair_done. It is instantiated once inside gcd_multi.

Test Plan:
- ops=(16,8,4), start pulse -> busy=1 next cycle; valid after at least 2 cycles; D=4; D holds 4 afterwards.
- Back-to-back jobs with start issued the cycle after each valid:
  - (3571,2711,1543) -> D=1;
  - (479,654,217) -> D=1;
  - (345,765,95) -> D=5.
  - Exactly one valid per job.
- Abort: start (3571,2711,1543), then 5 cycles later start (16,8,4) -> exactly one valid, D=4; no valid with D=1 ever appears.
- Zeros:
  - (0,0,0) -> D=0 with valid;
  - (0,12,18) -> D=6;
  - (7,0,0) -> D=7.
- Reset mid-CALC: deassert reset for 1 cycle during (3571,2711,1543) -> busy=0, valid=0, D=0 immediately. No valid afterwards until a new start; a new start of (16,8,4) then gives D=4.
- Parameter sweep with WIDTH=8, NUM_OPS=5, ops=(255,85,51,17,34) -> D=17. With GCD_CYCLE_CNT_EN defined, cycles equals the start-to-valid distance measured by the bench.
